// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory bus between instruction fetch and the data port.
// Optional fetch starvation guard: define ARB_FETCH_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ack,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ack,
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_be,
  input  logic [DW-1:0]   m_rdata,
  input  logic            m_ack,
  output logic            stall_if,
  output logic            stall_mem
);

  localparam int unsigned BW = DW / 8;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY_IF = 2'd1;
  localparam logic [1:0] S_BUSY_D  = 2'd2;

  logic [1:0]    state_q,    state_d;
  logic          m_req_q,    m_req_d;
  logic          m_we_q,     m_we_d;
  logic [AW-1:0] m_addr_q,   m_addr_d;
  logic [DW-1:0] m_wdata_q,  m_wdata_d;
  logic [BW-1:0] m_be_q,     m_be_d;
  logic          if_ack_q,   if_ack_d;
  logic          d_ack_q,    d_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q,  d_rdata_d;
  logic          grant_data;

`ifdef ARB_FETCH_STARVE_GUARD_EN
  logic [2:0] starve_q, starve_d;
  logic       starve_hit;

  // Once the data port has won STARVE_LIM times in a row over a waiting fetch, fetch wins next.
  assign starve_hit = (starve_q >= 3'(STARVE_LIM));
  assign grant_data = d_req & ~(starve_hit & if_req);

  always_comb begin
    starve_d = starve_q;
    if (state_q == S_IDLE) begin
      if (grant_data) begin
        if (!if_req)                starve_d = 3'd0;
        else if (starve_q != 3'd7)  starve_d = starve_q + 3'd1;
      end else if (if_req) begin
        starve_d = 3'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= 3'd0;
    else     starve_q <= starve_d;
  end
`else
  logic [31:0] unused_starve_lim;

  assign unused_starve_lim = 32'(STARVE_LIM);
  assign grant_data        = d_req;
`endif

  always_comb begin
    state_d    = state_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_be_d     = m_be_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_data) begin
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_be_d    = d_be;
          state_d   = S_BUSY_D;
        end else if (if_req) begin
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_addr_d = if_addr;
          m_be_d   = '0;
          state_d  = S_BUSY_IF;
        end
      end
      S_BUSY_IF: begin
        if (m_ack) begin
          m_req_d    = 1'b0;
          if_rdata_d = m_rdata;
          if_ack_d   = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_BUSY_D: begin
        if (m_ack) begin
          m_req_d = 1'b0;
          if (!m_we_q) d_rdata_d = m_rdata;
          d_ack_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        m_req_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_be_q     <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_be_q     <= m_be_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_be     = m_be_q;
  assign if_ack   = if_ack_q;
  assign d_ack    = d_ack_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

  // Stalls release in the ack cycle so the pipeline register captures the result.
  assign stall_if  = if_req & ~if_ack_q;
  assign stall_mem = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; the memory side is driven by hand.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_be;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_be;
  logic [DW-1:0] m_rdata;
  logic          m_ack;
  logic          stall_if;
  logic          stall_mem;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  dgrants;
    int  fgrants;
    int  d_before_f;
    bit  both_ack;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0; m_rdata = '0; m_ack = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // reset state
    check("rst_m_req",    64'(m_req),    64'h0);
    check("rst_m_addr",   64'(m_addr),   64'h0);
    check("rst_acks",     64'({if_ack, d_ack}), 64'h0);
    check("rst_rdata",    64'({if_rdata, d_rdata}), 64'h0);
    check("rst_stalls",   64'({stall_if, stall_mem}), 64'h0);

    // load, L=1
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF;
    #1 check("ld_stall_t", 64'(stall_mem), 64'h1);
    step();
    check("ld_mreq_t1",  64'(m_req),  64'h1);
    check("ld_maddr_t1", 64'(m_addr), 64'h100);
    check("ld_mwe_t1",   64'(m_we),   64'h0);
    check("ld_dack_t1",  64'(d_ack),  64'h0);
    step();
    check("ld_mreq_t2",  64'(m_req),     64'h1);
    check("ld_stall_t2", 64'(stall_mem), 64'h1);
    m_ack = 1'b1; m_rdata = 32'hDEADBEEF;
    step();
    m_ack = 1'b0;
    check("ld_dack_t3",  64'(d_ack),     64'h1);
    check("ld_rdata_t3", 64'(d_rdata),   64'hDEADBEEF);
    check("ld_mreq_t3",  64'(m_req),     64'h0);
    check("ld_stall_t3", 64'(stall_mem), 64'h0);
    d_req = 1'b0;
    step();
    check("ld_dack_t4",  64'(d_ack),   64'h0);
    check("ld_mreq_t4",  64'(m_req),   64'h0);

    // collision: store wins, fetch follows
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h55AA00FF; d_be = 4'hF;
    #1 check("col_stall_if0", 64'(stall_if), 64'h1);
    step();
    check("col_d_grant", 64'({m_req, m_we, m_addr}), {30'h0, 2'b11, 32'h200});
    check("col_wdata",   64'({m_wdata, m_be}), {28'h0, 32'h55AA00FF, 4'hF});
    check("col_stall_if1", 64'(stall_if), 64'h1);
    m_ack = 1'b1; m_rdata = 32'h0BADF00D;
    step();
    m_ack = 1'b0;
    check("col_dack",    64'({if_ack, d_ack}), 64'b01);
    check("col_st_rdata",64'(d_rdata), 64'hDEADBEEF);
    check("col_stall_if2", 64'(stall_if), 64'h1);
    d_req = 1'b0; d_we = 1'b0;
    step();
    check("col_f_grant", 64'({m_req, m_we, m_be, m_addr}), {26'h0, 2'b10, 4'h0, 32'h40});
    check("col_dack_off", 64'(d_ack), 64'h0);
    m_ack = 1'b1; m_rdata = 32'h00000013;
    step();
    m_ack = 1'b0;
    check("col_ifack",   64'({if_ack, d_ack}), 64'b10);
    check("col_if_rdata",64'(if_rdata), 64'h13);
    check("col_stall_if3", 64'(stall_if), 64'h0);
    if_req = 1'b0;
    step();
    check("col_idle",    64'({m_req, if_ack}), 64'h0);

    // fetch with L=3 and a spurious m_ack afterwards
    if_req = 1'b1; if_addr = 32'h0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("lat3_hold%0d", i), 64'({m_req, if_ack, m_addr}), {31'h0, 2'b10, 32'h0});
    end
    step();
    m_ack = 1'b1; m_rdata = 32'h00000093;
    step();
    m_ack = 1'b0;
    check("lat3_ifack",  64'(if_ack),   64'h1);
    check("lat3_rdata",  64'(if_rdata), 64'h93);
    if_req = 1'b0;
    step();
    check("lat3_pulse1", 64'(if_ack), 64'h0);
    m_ack = 1'b1; m_rdata = 32'hBAD0BAD0;
    step();
    m_ack = 1'b0;
    check("spur_acks",   64'({if_ack, d_ack, m_req}), 64'h0);
    check("spur_rdata",  64'({if_rdata, d_rdata}), {32'h93, 32'hDEADBEEF});

    // reset during BUSY_D
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    step();
    check("rst_mid_req", 64'(m_req), 64'h1);
    step();
    rst = 1'b1;
    #1 check("rst_mid_drop", 64'({m_req, m_addr}), 64'h0);
    step();
    rst = 1'b0; d_req = 1'b0;
    step();
    check("rst_mid_noack", 64'(d_ack), 64'h0);
    m_ack = 1'b1; m_rdata = 32'h77777777;
    step();
    m_ack = 1'b0;
    check("rst_late_ack", 64'({d_ack, if_ack, d_rdata}), 64'h0);
    d_req = 1'b1; d_addr = 32'h104;
    step();
    check("rst_next_req", 64'({m_req, m_addr}), {31'h0, 1'b1, 32'h104});
    m_ack = 1'b1; m_rdata = 32'hCAFEF00D;
    step();
    m_ack = 1'b0;
    check("rst_next_ack", 64'({d_ack, d_rdata}), {31'h0, 1'b1, 32'hCAFEF00D});
    d_req = 1'b0;
    step();

    // back-to-back loads, d_req held across the ack
    d_req = 1'b1; d_addr = 32'h500;
    step();
    check("b2b_req1", 64'({m_req, m_addr}), {31'h0, 1'b1, 32'h500});
    m_ack = 1'b1; m_rdata = 32'h11111111;
    step();
    m_ack = 1'b0;
    check("b2b_ack1", 64'({d_ack, m_req, d_rdata}), {30'h0, 2'b10, 32'h11111111});
    d_addr = 32'h504;
    step();
    check("b2b_req2", 64'({m_req, d_ack, m_addr}), {30'h0, 2'b10, 32'h504});
    m_ack = 1'b1; m_rdata = 32'h22222222;
    step();
    m_ack = 1'b0;
    check("b2b_ack2", 64'({d_ack, d_rdata}), {31'h0, 1'b1, 32'h22222222});
    d_req = 1'b0;
    step();
    check("b2b_pulse", 64'({d_ack, m_req}), 64'h0);

    // continuous data traffic with a waiting fetch
    dgrants = 0; fgrants = 0; d_before_f = -1; both_ack = 1'b0;
    d_req = 1'b1; d_addr = 32'h600; if_req = 1'b1; if_addr = 32'h80;
    for (int i = 0; i < 30; i++) begin
      step();
      if (if_ack && d_ack) both_ack = 1'b1;
      if (if_ack) if_req = 1'b0;
      if (m_req) begin
        if (m_addr == 32'h80) begin
          if (fgrants == 0) d_before_f = dgrants;
          fgrants++;
        end else begin
          dgrants++;
        end
      end
      m_ack = m_req; m_rdata = 32'h5A5A5A5A;
    end
`ifdef ARB_FETCH_STARVE_GUARD_EN
    check("starve_fetch", 64'(fgrants), 64'h1);
    check("starve_count", 64'(d_before_f), 64'h4);
`else
    check("strict_nofetch", 64'(fgrants), 64'h0);
    check("strict_dgrants", 64'(dgrants), 64'd15);
`endif
    check("starve_excl", 64'(both_ack), 64'h0);
    d_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (if_ack) if_req = 1'b0;
      m_ack = m_req;
    end
    m_ack = 1'b0;
    step();
    check("drain_idle", 64'({m_req, if_req}), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
